// File: rtl/sobel_stream_controller_if.sv
// rtl/sobel_stream_controller_if.sv - pixel sink/source handshake bundle for the Sobel frame sequencer
interface sobel_stream_controller_if;
   // sink side (gray pixels into the datapath)
   logic in_valid_i;
   logic in_ready_o;
   // source side (Sobel magnitudes out of the datapath)
   logic out_valid_o;
   logic out_ready_i;
   logic out_sop_o;
   logic out_eop_o;

   // master: the sequencer's view (it owns ready on the sink and valid/sop/eop on the source)
   modport master (
      input  in_valid_i,
      output in_ready_o,
      output out_valid_o,
      input  out_ready_i,
      output out_sop_o,
      output out_eop_o
   );

   // slave: the stream wrapper's view
   modport slave (
      output in_valid_i,
      input  in_ready_o,
      input  out_valid_o,
      output out_ready_i,
      input  out_sop_o,
      input  out_eop_o
   );
endinterface

// File: rtl/sobel_stream_controller.sv
// rtl/sobel_stream_controller.sv - one-frame sequencer: clear G memory, receive pixels, MAC sweep, stream results
module sobel_stream_controller #(
   parameter int IMG_X_SIZE = 100,
   parameter int IMG_Y_SIZE = 100
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             start_i,
   sobel_stream_controller_if.master        st,
   output logic                             busy_o,
   output logic                             done_o,
   input  logic                             inputRecieved_i,
   input  logic                             kernelResReady_i,
   input  logic                             imageProcessed_i,
   output logic                             cntrInputClear_o,
   output logic                             cntrKernelClear_o,
   output logic                             cntrMemGclear_o,
   output logic                             memGclear_o,
   output logic                             memImgWr_o,
   output logic                             cntrInputInc_o,
   output logic                             saveImgOrCalculate_o,
   output logic                             cntrKernelInc_o,
   output logic                             memGwr_o,
   output logic                             cntrMemGinc_o,
   output logic                             dataAvailable_o
);

   localparam int G_WORDS  = (IMG_X_SIZE - 2) * (IMG_Y_SIZE - 2);
   // keep the clear counter at least one bit wide even for a degenerate one-word G memory
   localparam int CLR_BITS = (G_WORDS > 1) ? $clog2(G_WORDS) : 1;
   localparam logic [CLR_BITS-1:0] CLR_LAST = CLR_BITS'(G_WORDS - 1);

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      CLEAR_G,
      RECV_INIT,
      RECV,
      CALC,
      ADVANCE,
      SEND,
      DONE
   } state_t;

   state_t              state;
   logic [CLR_BITS-1:0] clr_cnt;
   logic                first_pix;

   logic                in_xfer;
   logic                out_xfer;

   // handshakes are only meaningful in the states that raise ready/valid
   assign in_xfer  = (state == RECV) && st.in_valid_i;
   assign out_xfer = (state == SEND) && st.out_ready_i;

   // state sequencing, G-memory clear counter and first-output-pixel flag
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         clr_cnt   <= '0;
         first_pix <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  state <= INIT;
               end
            end
            INIT: begin
               clr_cnt <= '0;
               state   <= CLEAR_G;
            end
            CLEAR_G: begin
               clr_cnt <= clr_cnt + 1'b1;
               // the last address is still written in this cycle
               if (clr_cnt == CLR_LAST) begin
                  state <= RECV_INIT;
               end
            end
            RECV_INIT: begin
               state <= RECV;
            end
            RECV: begin
               if (in_xfer && inputRecieved_i) begin
                  state <= CALC;
               end
            end
            CALC: begin
               // ninth tap is accumulated in the same cycle the flag is seen
               if (kernelResReady_i) begin
                  state <= ADVANCE;
               end
            end
            ADVANCE: begin
               if (imageProcessed_i) begin
                  state     <= SEND;
                  first_pix <= 1'b1;
               end else begin
                  state <= CALC;
               end
            end
            SEND: begin
               if (out_xfer) begin
                  first_pix <= 1'b0;
                  if (imageProcessed_i) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // datapath controls and stream handshakes decoded from state and live handshake inputs
   always_comb begin
      busy_o               = 1'b0;
      done_o               = 1'b0;
      st.in_ready_o        = 1'b0;
      st.out_valid_o       = 1'b0;
      st.out_sop_o         = 1'b0;
      st.out_eop_o         = 1'b0;
      cntrInputClear_o     = 1'b0;
      cntrKernelClear_o    = 1'b0;
      cntrMemGclear_o      = 1'b0;
      memGclear_o          = 1'b0;
      memImgWr_o           = 1'b0;
      cntrInputInc_o       = 1'b0;
      saveImgOrCalculate_o = 1'b0;
      cntrKernelInc_o      = 1'b0;
      memGwr_o             = 1'b0;
      cntrMemGinc_o        = 1'b0;
      dataAvailable_o      = 1'b0;
      case (state)
         IDLE: begin
            busy_o = 1'b0;
         end
         INIT: begin
            busy_o            = 1'b1;
            cntrInputClear_o  = 1'b1;
            cntrKernelClear_o = 1'b1;
            cntrMemGclear_o   = 1'b1;
         end
         CLEAR_G: begin
            // the input counter doubles as the G-memory clear address
            busy_o         = 1'b1;
            memGclear_o    = 1'b1;
            cntrInputInc_o = 1'b1;
         end
         RECV_INIT: begin
            busy_o           = 1'b1;
            cntrInputClear_o = 1'b1;
         end
         RECV: begin
            busy_o         = 1'b1;
            st.in_ready_o  = 1'b1;
            memImgWr_o     = in_xfer;
            cntrInputInc_o = in_xfer;
         end
         CALC: begin
            busy_o               = 1'b1;
            saveImgOrCalculate_o = 1'b1;
            memGwr_o             = 1'b1;
            cntrKernelInc_o      = 1'b1;
         end
         ADVANCE: begin
            busy_o            = 1'b1;
            cntrKernelClear_o = 1'b1;
            if (imageProcessed_i) begin
               cntrMemGclear_o = 1'b1;
            end else begin
               cntrMemGinc_o = 1'b1;
            end
         end
         SEND: begin
            // valid is never retracted; backpressure simply holds the address
            busy_o          = 1'b1;
            st.out_valid_o  = 1'b1;
            dataAvailable_o = 1'b1;
            st.out_sop_o    = first_pix;
            st.out_eop_o    = imageProcessed_i;
            cntrMemGinc_o   = out_xfer;
         end
         DONE: begin
            busy_o          = 1'b1;
            done_o          = 1'b1;
            cntrMemGclear_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sobel_stream_controller.sv
// tb/tb_sobel_stream_controller.sv - randomized frame-level bench for the Sobel frame sequencer
module tb_sobel_stream_controller;

   localparam int X  = 4;
   localparam int Y  = 4;
   localparam int G  = (X - 2) * (Y - 2);
   localparam int XY = X * Y;

   localparam int B_IRDY  = 16;
   localparam int B_OVAL  = 15;
   localparam int B_SOP   = 14;
   localparam int B_EOP   = 13;
   localparam int B_BUSY  = 12;
   localparam int B_DONE  = 11;
   localparam int B_ICLR  = 10;
   localparam int B_KCLR  = 9;
   localparam int B_GCCLR = 8;
   localparam int B_GCLR  = 7;
   localparam int B_IWR   = 6;
   localparam int B_IINC  = 5;
   localparam int B_SAVE  = 4;
   localparam int B_KINC  = 3;
   localparam int B_GWR   = 2;
   localparam int B_GINC  = 1;
   localparam int B_AVAIL = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic busy, done;
   logic f_irecv, f_kready, f_gdone;
   logic c_iclr, c_kclr, c_gcclr, c_gclr, c_iwr, c_iinc, c_save, c_kinc, c_gwr, c_ginc, c_avail;

   sobel_stream_controller_if st ();

   always #5 clk = ~clk;

   sobel_stream_controller #(
      .IMG_X_SIZE(X),
      .IMG_Y_SIZE(Y)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .start_i              (start),
      .st                   (st),
      .busy_o               (busy),
      .done_o               (done),
      .inputRecieved_i      (f_irecv),
      .kernelResReady_i     (f_kready),
      .imageProcessed_i     (f_gdone),
      .cntrInputClear_o     (c_iclr),
      .cntrKernelClear_o    (c_kclr),
      .cntrMemGclear_o      (c_gcclr),
      .memGclear_o          (c_gclr),
      .memImgWr_o           (c_iwr),
      .cntrInputInc_o       (c_iinc),
      .saveImgOrCalculate_o (c_save),
      .cntrKernelInc_o      (c_kinc),
      .memGwr_o             (c_gwr),
      .cntrMemGinc_o        (c_ginc),
      .dataAvailable_o      (c_avail)
   );

   // stand-in datapath counters that produce the three finished flags
   int in_cnt, k_cnt, g_cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_cnt <= 0;
         k_cnt  <= 0;
         g_cnt  <= 0;
      end else begin
         if (c_iclr) in_cnt <= 0; else if (c_iinc) in_cnt <= in_cnt + 1;
         if (c_kclr) k_cnt <= 0; else if (c_kinc) k_cnt <= k_cnt + 1;
         if (c_gcclr) g_cnt <= 0; else if (c_ginc) g_cnt <= g_cnt + 1;
      end
   end
   assign f_irecv  = (in_cnt == XY - 1);
   assign f_kready = (k_cnt == 8);
   assign f_gdone  = (g_cnt == G - 1);

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // frame reference: cycle t counted from the INIT cycle, phases derived from pixel/transfer counts
   bit m_on;
   int m_t, m_rx, m_c0, m_tx, frames;

   int cyc, vec_bad, ev_busy, ev_wr, wr_bad, ev_gwr, ev_adv, ev_gclr, ev_iclr, ev_xfer;
   int sop_n, sop_idx, eop_n, eop_idx, ev_hold, hold_bad, ev_done, done_gap, last_xfer, gap;

   function automatic logic [16:0] dut_vec();
      return {st.in_ready_o, st.out_valid_o, st.out_sop_o, st.out_eop_o, busy, done,
              c_iclr, c_kclr, c_gcclr, c_gclr, c_iwr, c_iinc, c_save, c_kinc, c_gwr, c_ginc, c_avail};
   endfunction

   function automatic logic [16:0] model_exp(input logic v, input logic r);
      logic [16:0] e;
      int o;
      e = '0;
      if (m_on) begin
         e[B_BUSY] = 1'b1;
         if (m_t == 0) begin
            e[B_ICLR] = 1'b1; e[B_KCLR] = 1'b1; e[B_GCCLR] = 1'b1;
         end else if (m_t <= G) begin
            e[B_GCLR] = 1'b1; e[B_IINC] = 1'b1;
         end else if (m_t == G + 1) begin
            e[B_ICLR] = 1'b1;
         end else if (m_c0 < 0) begin
            e[B_IRDY] = 1'b1; e[B_IWR] = v; e[B_IINC] = v;
         end else if (m_t < m_c0 + 10 * G) begin
            o = m_t - m_c0;
            if (o % 10 != 9) begin
               e[B_SAVE] = 1'b1; e[B_KINC] = 1'b1; e[B_GWR] = 1'b1;
            end else begin
               e[B_KCLR] = 1'b1;
               if (o / 10 == G - 1) e[B_GCCLR] = 1'b1; else e[B_GINC] = 1'b1;
            end
         end else if (m_tx < G) begin
            e[B_OVAL] = 1'b1; e[B_AVAIL] = 1'b1;
            e[B_SOP] = (m_tx == 0); e[B_EOP] = (m_tx == G - 1); e[B_GINC] = r;
         end else begin
            e[B_DONE] = 1'b1; e[B_GCCLR] = 1'b1;
         end
      end
      return e;
   endfunction

   function automatic bit m_in_recv();
      return m_on && (m_t > G + 1) && (m_c0 < 0);
   endfunction

   function automatic bit m_in_send();
      return m_on && (m_c0 >= 0) && (m_t >= m_c0 + 10 * G) && (m_tx < G);
   endfunction

   task automatic clear_stats();
      vec_bad = 0; ev_busy = 0; ev_wr = 0; wr_bad = 0; ev_gwr = 0; ev_adv = 0; ev_gclr = 0;
      ev_iclr = 0; ev_xfer = 0; sop_n = 0; sop_idx = 0; eop_n = 0; eop_idx = 0; ev_hold = 0;
      hold_bad = 0; ev_done = 0; done_gap = 0; last_xfer = 0; gap = 0; frames = 0;
   endtask

   // one clock: drive inputs after the edge, compare before the next one, then advance the reference
   task automatic step(input logic s, input logic v, input logic r);
      logic [16:0] e, o;
      @(posedge clk);
      #1;
      start = s; st.in_valid_i = v; st.out_ready_i = r;
      #3;
      e = model_exp(v, r);
      o = dut_vec();
      if (o !== e) begin
         vec_bad++;
         if (vec_bad <= 3) check("cycle_outputs", 32'(o), 32'(e));
      end
      ev_busy += int'(o[B_BUSY]);
      ev_wr   += int'(o[B_IWR]);
      if (o[B_IWR] && !v) wr_bad++;
      ev_gwr  += int'(o[B_GWR]);
      if (o[B_KCLR] && !o[B_ICLR]) ev_adv++;
      ev_gclr += int'(o[B_GCLR]);
      ev_iclr += int'(o[B_ICLR]);
      if (o[B_OVAL] && r) begin
         ev_xfer++;
         last_xfer = cyc;
         if (o[B_SOP]) begin sop_n++; sop_idx = ev_xfer; end
         if (o[B_EOP]) begin eop_n++; eop_idx = ev_xfer; end
      end
      if (o[B_OVAL] && !r) begin
         ev_hold++;
         if (o[B_GINC] || o[B_SOP]) hold_bad++;
      end
      if (o[B_DONE]) begin ev_done++; done_gap = cyc - last_xfer; end
      if (ev_done == 1 && !o[B_BUSY]) gap++;
      if (!m_on) begin
         if (s) begin m_on = 1'b1; m_t = 0; m_rx = 0; m_c0 = -1; m_tx = 0; end
      end else begin
         if (e[B_IRDY] && v) begin
            m_rx++;
            if (m_rx == XY) m_c0 = m_t + 1;
         end
         if (e[B_OVAL] && r) m_tx++;
         if (e[B_DONE]) begin m_on = 1'b0; frames++; end
         m_t++;
      end
      cyc++;
   endtask

   // mode 0 ideal, 1 sink stall + source backpressure, 2 stray starts, 3 start held, 4 random
   task automatic run(input int mode, input int nframes, input int budget);
      int k;
      int held;
      logic s, v, r;
      k = 0; held = 0;
      while (frames < nframes && k < budget) begin
         s = (k == 0); v = 1'b1; r = 1'b1;
         case (mode)
            1: begin
               v = (k % 3 == 0);
               if (m_in_send() && m_tx == 1 && held < 5) begin r = 1'b0; held++; end
            end
            2: if ((m_in_recv() || m_in_send()) && ($urandom % 2 == 1)) s = 1'b1;
            3: s = 1'b1;
            4: begin
               s = ($urandom % 4 == 0); v = ($urandom % 4 != 0); r = ($urandom % 4 != 0);
            end
            default: ;
         endcase
         step(s, v, r);
         k++;
      end
      check("frames_completed", frames, nframes);
   endtask

   initial begin
      logic [16:0] snap;
      int k;
      st.in_valid_i = 1'b0; st.out_ready_i = 1'b0;
      m_on = 1'b0; m_t = 0; m_rx = 0; m_c0 = -1; m_tx = 0; cyc = 0;
      clear_stats();

      #7;
      check("reset_outputs", 32'(dut_vec()), 32'h0);
      #1 rst = 1'b1;

      // ideal frame
      clear_stats();
      run(0, 1, 400);
      check("ideal_busy_cycles", ev_busy, 1 + G + 1 + XY + 10 * G + G + 1);
      check("ideal_clear_cycles", ev_gclr, G);
      check("ideal_img_writes", ev_wr, XY);
      check("ideal_g_writes", ev_gwr, 9 * G);
      check("ideal_advances", ev_adv, G);
      check("ideal_transfers", ev_xfer, G);
      check("ideal_sop_count", sop_n, 1);
      check("ideal_sop_index", sop_idx, 1);
      check("ideal_eop_count", eop_n, 1);
      check("ideal_eop_index", eop_idx, G);
      check("ideal_done_count", ev_done, 1);
      check("ideal_done_gap", done_gap, 1);
      check("ideal_vec_mismatch", vec_bad, 0);

      // sink stall and source backpressure
      clear_stats();
      run(1, 1, 600);
      check("stall_img_writes", ev_wr, XY);
      check("stall_write_without_valid", wr_bad, 0);
      check("stall_transfers", ev_xfer, G);
      check("stall_hold_cycles", ev_hold, 5);
      check("stall_hold_ginc_or_sop", hold_bad, 0);
      check("stall_sop_count", sop_n, 1);
      check("stall_vec_mismatch", vec_bad, 0);

      // stray start pulses mid-frame
      clear_stats();
      run(2, 1, 400);
      check("stray_input_clears", ev_iclr, 2);
      check("stray_busy_cycles", ev_busy, 1 + G + 1 + XY + 10 * G + G + 1);
      check("stray_done_count", ev_done, 1);
      check("stray_vec_mismatch", vec_bad, 0);

      // asynchronous reset in the MAC sweep
      clear_stats();
      step(1'b1, 1'b1, 1'b1);
      k = 0;
      while (!(m_c0 >= 0 && m_t >= m_c0 + 3) && k < 300) begin
         step(1'b0, 1'b1, 1'b1);
         k++;
      end
      snap = dut_vec();
      check("calc_before_reset", 32'(snap[B_GWR]), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("async_reset_outputs", 32'(dut_vec()), 32'h0);
      #5;
      m_on = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
      check("reset_no_done", ev_done, 0);
      check("reset_vec_mismatch", vec_bad, 0);

      // back-to-back frames with start held
      clear_stats();
      run(3, 2, 800);
      check("b2b_busy_cycles", ev_busy, 2 * (1 + G + 1 + XY + 10 * G + G + 1));
      check("b2b_idle_gap", gap, 1);
      check("b2b_img_writes", ev_wr, 2 * XY);
      check("b2b_transfers", ev_xfer, 2 * G);
      check("b2b_done_count", ev_done, 2);
      check("b2b_vec_mismatch", vec_bad, 0);

      // randomized handshakes and start noise
      clear_stats();
      start = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      run(4, 3, 3000);
      check("rand_img_writes", ev_wr, 3 * XY);
      check("rand_transfers", ev_xfer, 3 * G);
      check("rand_done_count", ev_done, 3);
      check("rand_vec_mismatch", vec_bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sobel_stream_controller.md
Name: sobel_stream_controller

Overview:
- FSM that sequences the Sobel datapath for one frame:
  - clear the Gx/Gy accumulator memories;
  - receive IMG_X_SIZE*IMG_Y_SIZE gray pixels over a valid/ready sink;
  - run the 3x3 MAC sweep for every G pixel;
  - stream (IMG_X_SIZE-2)*(IMG_Y_SIZE-2) result pixels over a valid/ready source with sop/eop.
- Sits between the Avalon-ST wrapper and the datapath. Drives every datapath control input and consumes its three finished flags.

Parameters:
- IMG_X_SIZE, 100, image width in pixels (>=4)
- IMG_Y_SIZE, 100, image height in pixels (>=4)
- Derived: G_WORDS = (IMG_X_SIZE-2)*(IMG_Y_SIZE-2); CLR_BITS = $clog2(G_WORDS)

Ports:
- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  start one frame; sampled only in IDLE
- in_valid_i  in  1  sink pixel valid
- in_ready_o  out  1  sink ready
- out_valid_o  out  1  source pixel valid
- out_ready_i  in  1  source ready
- out_sop_o  out  1  first output pixel of frame
- out_eop_o  out  1  last output pixel of frame
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the last output transfer
- inputRecieved_i  in  1  datapath: input counter at last pixel
- kernelResReady_i  in  1  datapath: kernel counter at (2,2)
- imageProcessed_i  in  1  datapath: G counter at last pixel
- cntrInputClear_o, cntrKernelClear_o, cntrMemGclear_o, memGclear_o, memImgWr_o, cntrInputInc_o, saveImgOrCalculate_o, cntrKernelInc_o, memGwr_o, cntrMemGinc_o, dataAvailable_o  out  1 each  datapath controls

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE, clear counter=0, all outputs 0.
  - A reset asserted mid-frame aborts the frame immediately; no done_o pulse.
- Outputs are Moore/Mealy combinational decodes of state plus handshake inputs. Every control not listed for a state is 0.
- IDLE: busy_o=0. start_i=1 -> INIT.
- INIT (1 cycle): cntrInputClear_o=cntrKernelClear_o=cntrMemGclear_o=1; clear counter <= 0 -> CLEAR_G.
- CLEAR_G:
  - memGclear_o=1, cntrInputInc_o=1, saveImgOrCalculate_o=0; clear counter +1 per cycle.
  - When counter==G_WORDS-1 (that cycle still writes) -> RECV_INIT. Exactly G_WORDS cycles.
- RECV_INIT (1 cycle): cntrInputClear_o=1 -> RECV.
- RECV:
  - in_ready_o=1, saveImgOrCalculate_o=0.
  - Transfer = in_valid_i & in_ready_o -> memImgWr_o=1, cntrInputInc_o=1.
  - Transfer with inputRecieved_i=1 -> CALC.
  - in_valid_i=0 stalls with no writes.
- CALC:
  - saveImgOrCalculate_o=1, memGwr_o=1, cntrKernelInc_o=1 every cycle.
  - kernelResReady_i=1 (9th tap written this cycle) -> ADVANCE.
- ADVANCE (1 cycle): cntrKernelClear_o=1.
  - If imageProcessed_i=1: cntrMemGclear_o=1 -> SEND.
  - Else: cntrMemGinc_o=1 -> CALC.
  - Per G pixel: 10 cycles.
- SEND:
  - out_valid_o=1, dataAvailable_o=1.
  - out_sop_o=1 while the first-pixel flag is set; the flag is set on SEND entry and cleared on the first transfer.
  - out_eop_o = imageProcessed_i.
  - Transfer = out_valid_o & out_ready_i -> cntrMemGinc_o=1.
  - Transfer with imageProcessed_i=1 -> DONE.
  - out_ready_i=0 holds the same pixel; valid stays high (no retraction).
- DONE (1 cycle): done_o=1, cntrMemGclear_o=1 -> IDLE.
- start_i outside IDLE is ignored.
- G_WORDS==1 edge: out_sop_o and out_eop_o are both high on the single transfer.
- Frame cycle count with ideal handshakes: 1 + G_WORDS + 1 + X*Y + 10*G_WORDS + G_WORDS + 1.

Test Plan:
- IMG 4x4, start pulse, in_valid_i/out_ready_i held 1:
  - CLEAR_G lasts 4 cycles with memGclear_o=1;
  - 16 memImgWr_o pulses;
  - 36 memGwr_o pulses and 4 ADVANCE cycles;
  - 4 output transfers, sop on the 1st, eop on the 4th;
  - done_o one cycle after the 4th transfer; total 1+4+1+16+40+4+1 cycles.
- Sink stall: in_valid_i toggled 1,0,0,1,... -> memImgWr_o only on valid cycles; exactly 16 writes; CALC entered only after write with inputRecieved_i.
- Source backpressure: out_ready_i=0 for 5 cycles at pixel 2 -> out_valid_o stays 1, cntrMemGinc_o=0 during the stall, sop not re-asserted, 4 transfers total.
- Async reset: assert rst_i=0 mid-CALC, off-edge -> all outputs 0 immediately; state IDLE after release; no done_o.
- start_i pulsed during RECV and SEND -> no INIT re-entry and no counter clears; frame completes normally.
- Back-to-back frames: start_i held 1 -> IDLE for one cycle after DONE, then INIT; second frame identical in cycle count and pulse counts.
